// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with boot/run/halt FSM, redirects and epoch tagging
module pc_gen #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     C_EXT     = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            is_compressed,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_take,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign,
  output logic [1:0]      epoch,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  // Low address bits that must be zero for a legal fetch address.
  localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic            misalign_q;
  logic [1:0]      epoch_q;
  logic [XLEN-1:0] pc_step;
  logic            br_misaligned;
  logic [XLEN-1:0] trap_pc;

  // Sequential increment size and redirect address qualification.
  always_comb begin
    pc_step       = ((C_EXT != 0) && is_compressed) ? XLEN'(2) : XLEN'(4);
    br_misaligned = |(br_target & ALIGN_MASK);
    trap_pc       = trap_vec & ~ALIGN_MASK;
  end

  // Control FSM: boot, run with prioritised redirects, and halt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      epoch_q    <= 2'd0;
    end else begin
      // misalign is a single-cycle pulse unless re-armed below
      misalign_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q <= RUN;
        end
        RUN: begin
          if (trap_take) begin
            pc_q    <= trap_pc;
            epoch_q <= epoch_q + 2'd1;
          end else if (br_taken) begin
            if (br_misaligned) begin
              misalign_q <= 1'b1;
            end else begin
              pc_q    <= br_target;
              epoch_q <= epoch_q + 2'd1;
            end
          end else if (halt_req) begin
            state_q <= HALT;
          end else if (!stall) begin
            pc_q <= pc_q + pc_step;
          end
        end
        HALT: begin
          if (trap_take) begin
            pc_q    <= trap_pc;
            epoch_q <= epoch_q + 2'd1;
            state_q <= RUN;
          end else if (resume) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= BOOT;
          pc_q    <= RESET_VEC;
        end
      endcase
    end
  end

  // Outputs come straight from the state registers.
  always_comb begin
    pc_out   = pc_q;
    pc_valid = (state_q == RUN);
    misalign = misalign_q;
    epoch    = epoch_q;
    state    = state_q;
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed vector bench for pc_gen with C_EXT=0 and C_EXT=1 instances
module tb_pc_gen;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SR = 2'b01;
  localparam logic [1:0] SH = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n, stall, is_compressed, br_taken, trap_take, halt_req, resume;
  logic [63:0] br_target, trap_vec;
  logic [63:0] pc0, pc1;
  logic        valid0, valid1, mis0, mis1;
  logic [1:0]  ep0, ep1, st0, st1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(64), .RESET_VEC(64'h0), .C_EXT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .is_compressed(is_compressed),
    .br_taken(br_taken), .br_target(br_target), .trap_take(trap_take), .trap_vec(trap_vec),
    .halt_req(halt_req), .resume(resume), .pc_out(pc0), .pc_valid(valid0),
    .misalign(mis0), .epoch(ep0), .state(st0)
  );

  pc_gen #(.XLEN(64), .RESET_VEC(64'h0), .C_EXT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .is_compressed(is_compressed),
    .br_taken(br_taken), .br_target(br_target), .trap_take(trap_take), .trap_vec(trap_vec),
    .halt_req(halt_req), .resume(resume), .pc_out(pc1), .pc_valid(valid1),
    .misalign(mis1), .epoch(ep1), .state(st1)
  );

  typedef struct {
    logic        rst_n, stall, comp, br;
    logic [63:0] tgt;
    logic        trap;
    logic [63:0] tvec;
    logic        halt, resume;
    logic [63:0] pc0, pc1;
    logic [1:0]  st;
    logic        valid, mis0, mis1;
    logic [1:0]  ep0, ep1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst_n, logic stl, logic comp, logic br, logic [63:0] tgt,
                             logic trap, logic [63:0] tvec, logic halt, logic res,
                             logic [63:0] e_pc0, logic [63:0] e_pc1, logic [1:0] e_st,
                             logic e_valid, logic e_mis0, logic e_mis1,
                             logic [1:0] e_ep0, logic [1:0] e_ep1);
    vec_t r;
    r.rst_n = rst_n; r.stall = stl; r.comp = comp; r.br = br; r.tgt = tgt;
    r.trap = trap; r.tvec = tvec; r.halt = halt; r.resume = res;
    r.pc0 = e_pc0; r.pc1 = e_pc1; r.st = e_st; r.valid = e_valid;
    r.mis0 = e_mis0; r.mis1 = e_mis1; r.ep0 = e_ep0; r.ep1 = e_ep1;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic stl, input logic comp, input logic br,
                       input logic [63:0] tgt, input logic trap, input logic [63:0] tvec,
                       input logic halt, input logic res);
    @(negedge clk);
    reset_n = rst_n; stall = stl; is_compressed = comp; br_taken = br; br_target = tgt;
    trap_take = trap; trap_vec = tvec; halt_req = halt; resume = res;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; is_compressed = 1'b0; br_taken = 1'b0; br_target = '0;
    trap_take = 1'b0; trap_vec = '0; halt_req = 1'b0; resume = 1'b0;

    //            rst st cp br tgt                    tr tvec    hl rs  pc0                    pc1                    st valid m0 m1 e0 e1
    vecs.push_back(v(0, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h0,                64'h0,                SB, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h0,                64'h0,                SR, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h4,                64'h4,                SR, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h8,                64'h8,                SR, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 1, 64'h100,              0, 64'h0,  0, 0, 64'h100,              64'h100,              SR, 1, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 1, 0, 64'h0,                0, 64'h0,  0, 0, 64'h104,              64'h102,              SR, 1, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h108,              64'h106,              SR, 1, 0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0, 1, 64'h200,              0, 64'h0,  0, 0, 64'h200,              64'h200,              SR, 1, 0, 0, 2, 2));
    vecs.push_back(v(1, 1, 0, 1, 64'h400,              0, 64'h0,  0, 0, 64'h400,              64'h400,              SR, 1, 0, 0, 3, 3));
    vecs.push_back(v(1, 0, 0, 1, 64'h402,              0, 64'h0,  0, 0, 64'h400,              64'h402,              SR, 1, 1, 0, 3, 0));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h404,              64'h406,              SR, 1, 0, 0, 3, 0));
    vecs.push_back(v(1, 0, 0, 1, 64'h123,              1, 64'h803,1, 0, 64'h800,              64'h802,              SR, 1, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  1, 0, 64'h800,              64'h802,              SH, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 1, 64'h40,               0, 64'h0,  0, 0, 64'h800,              64'h802,              SH, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 1, 64'h41,               0, 64'h0,  1, 0, 64'h800,              64'h802,              SH, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 1, 64'h800,              64'h802,              SR, 1, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h804,              64'h806,              SR, 1, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC,0,64'h0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC,64'hFFFF_FFFF_FFFF_FFFC,SR, 1, 0, 0, 1, 2));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h0,                64'h0,                SR, 1, 0, 0, 1, 2));
    vecs.push_back(v(1, 0, 0, 1, 64'h10,               0, 64'h0,  0, 0, 64'h10,               64'h10,               SR, 1, 0, 0, 2, 3));
    vecs.push_back(v(1, 0, 0, 1, 64'h20,               0, 64'h0,  0, 0, 64'h20,               64'h20,               SR, 1, 0, 0, 3, 0));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                1, 64'h30, 0, 0, 64'h30,               64'h30,               SR, 1, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  1, 0, 64'h30,               64'h30,               SH, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                1, 64'h51, 0, 1, 64'h50,               64'h50,               SR, 1, 0, 0, 1, 2));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  1, 0, 64'h50,               64'h50,               SH, 0, 0, 0, 1, 2));
    vecs.push_back(v(0, 0, 0, 0, 64'h0,                1, 64'h60, 0, 0, 64'h0,                64'h0,                SB, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 1, 64'h80,               1, 64'h70, 1, 0, 64'h0,                64'h0,                SR, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h4,                64'h4,                SR, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 1, 64'h3,                0, 64'h0,  0, 0, 64'h4,                64'h4,                SR, 1, 1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 64'h100,              0, 64'h0,  0, 0, 64'h0,                64'h0,                SB, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h0,                64'h0,                SR, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h0,                64'h0,                SR, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 64'h0,                0, 64'h0,  0, 0, 64'h4,                64'h4,                SR, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].comp, vecs[i].br, vecs[i].tgt,
            vecs[i].trap, vecs[i].tvec, vecs[i].halt, vecs[i].resume);
      check("pc0",      i, pc0,           vecs[i].pc0);
      check("pc1",      i, pc1,           vecs[i].pc1);
      check("state0",   i, 64'(st0),      64'(vecs[i].st));
      check("state1",   i, 64'(st1),      64'(vecs[i].st));
      check("pc_valid0",i, 64'(valid0),   64'(vecs[i].valid));
      check("pc_valid1",i, 64'(valid1),   64'(vecs[i].valid));
      check("misalign0",i, 64'(mis0),     64'(vecs[i].mis0));
      check("misalign1",i, 64'(mis1),     64'(vecs[i].mis1));
      check("epoch0",   i, 64'(ep0),      64'(vecs[i].ep0));
      check("epoch1",   i, 64'(ep1),      64'(vecs[i].ep1));
    end

    // Misalign pulse lasts one cycle even while the pipe stalls afterwards.
    drive(1, 0, 0, 1, 64'h6, 0, 64'h0, 0, 0);
    check("seq_mis_pulse", 100, 64'(mis0), 64'h1);
    check("seq_mis_pc0",   100, pc0,       64'h4);
    check("seq_mis_ep0",   100, 64'(ep0),  64'h0);
    check("seq_c_pc1",     100, pc1,       64'h6);
    check("seq_c_ep1",     100, 64'(ep1),  64'h1);
    drive(1, 1, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    check("seq_mis_clear", 101, 64'(mis0), 64'h0);
    check("seq_stall_pc0", 101, pc0,       64'h4);
    check("seq_stall_pc1", 101, pc1,       64'h6);
    drive(1, 0, 0, 0, 64'h0, 0, 64'h0, 0, 0);
    check("seq_step_pc0",  102, pc0,       64'h8);
    check("seq_step_pc1",  102, pc1,       64'hA);
    check("seq_step_mis",  102, 64'(mis0), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
